// File: rtl/led_recv_if.sv
// Pixel output handshake bundle for led_recv: word, frame position, valid/ready.
interface led_recv_if #(
  parameter int LED_NUM = 4
) ();
  logic [23:0]                pix_data;
  logic [$clog2(LED_NUM)-1:0] pix_idx;
  logic                       pix_valid;
  logic                       pix_ready;

  modport master (output pix_data, output pix_idx, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_idx, input pix_valid, output pix_ready);
endinterface

// File: rtl/led_recv.sv
// led_recv: receives serial LED frames (cko/sdi, MSB first), splits them into
// 24-bit words tagged with their frame position, and buffers them for a
// valid/ready consumer. A frame ends after IDLE_CNT clocks with no cko edge.
// Macro LED_RECV_SYNC_EN adds 2-flop synchronizers on cko_i/sdi.
module led_recv #(
  parameter int LED_NUM    = 4,
  parameter int IDLE_CNT   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cko_i,
  input  logic       sdi,
  led_recv_if.master pix,
  output logic       frame_done,
  output logic       frame_err,
  output logic       ovf
);
  localparam int IW  = $clog2(LED_NUM);
  localparam int CW  = $clog2(LED_NUM + 1);
  localparam int ICW = $clog2(IDLE_CNT);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cko_s, r_sdi_s, r_cko_d;
  logic            w_edge;
  logic [ICW-1:0]  r_idle_cnt;
  logic [4:0]      r_bit_cnt;
  logic [CW-1:0]   r_word_cnt;
  logic            r_extra;
  logic [23:0]     r_shift;
  logic            r_wr_en;
  logic [23:0]     r_wr_data;
  logic [IW-1:0]   r_wr_idx;
  logic [IW+23:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic            r_ovf;
  logic            w_full, w_empty, w_rd, w_wr;

`ifdef LED_RECV_SYNC_EN
  logic r_cko_m, r_sdi_m;
  // Input stage: two-flop synchronizers plus the edge-detect history flop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cko_m <= 1'b0;
      r_sdi_m <= 1'b0;
      r_cko_s <= 1'b0;
      r_sdi_s <= 1'b0;
      r_cko_d <= 1'b0;
    end else begin
      r_cko_m <= cko_i;
      r_sdi_m <= sdi;
      r_cko_s <= r_cko_m;
      r_sdi_s <= r_sdi_m;
      r_cko_d <= r_cko_s;
    end
  end
`else
  // Input stage: single register for same-clock-domain senders, plus edge history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cko_s <= 1'b0;
      r_sdi_s <= 1'b0;
      r_cko_d <= 1'b0;
    end else begin
      r_cko_s <= cko_i;
      r_sdi_s <= sdi;
      r_cko_d <= r_cko_s;
    end
  end
`endif

  assign w_edge = r_cko_s & ~r_cko_d;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and frame status pulses
  always_comb begin
    w_state_nxt = r_state;
    frame_done  = 1'b0;
    frame_err   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_edge) w_state_nxt = S_SHIFT;
      S_SHIFT: if (!w_edge && r_idle_cnt == ICW'(IDLE_CNT - 1)) w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_state_nxt = S_IDLE;
        frame_done  = 1'b1;
        frame_err   = (r_bit_cnt != 5'd0) || (r_word_cnt != CW'(LED_NUM)) || r_extra;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Idle counter: restarts on every cko edge while shifting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            r_idle_cnt <= '0;
    else if (r_state != S_SHIFT || w_edge) r_idle_cnt <= '0;
    else                                  r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  // Bit shifting, word formation and frame counters; words past LED_NUM are dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_extra    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_wr_idx   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_state == S_LATCH) begin
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_extra    <= 1'b0;
      end else if (w_edge) begin
        r_shift <= {r_shift[22:0], r_sdi_s};
        if (r_bit_cnt == 5'd23) begin
          r_bit_cnt <= '0;
          if (r_word_cnt == CW'(LED_NUM)) begin
            r_extra <= 1'b1;
          end else begin
            r_wr_en    <= 1'b1;
            r_wr_data  <= {r_shift[22:0], r_sdi_s};
            r_wr_idx   <= r_word_cnt[IW-1:0];
            r_word_cnt <= r_word_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // Full buffer still accepts a write when the head is being read in the same cycle
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_rd    = pix.pix_valid && pix.pix_ready;
  assign w_wr    = r_wr_en && (!w_full || w_rd);

  // Word buffer storage and pointers, wrapping modulo FIFO_DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {r_wr_idx, r_wr_data};
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky overflow when a word arrives at a full buffer with no read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_ovf <= 1'b0;
    else if (r_wr_en && w_full && !w_rd) r_ovf <= 1'b1;
  end

  assign ovf           = r_ovf;
  assign pix.pix_valid = !w_empty;
  assign pix.pix_data  = r_mem[r_rd_ptr[AW-1:0]][23:0];
  assign pix.pix_idx   = r_mem[r_rd_ptr[AW-1:0]][IW+23:24];
endmodule

// File: tb/tb_led_recv.sv
// Scoreboard bench for led_recv: expected words/frame results are queued as
// stimulus is driven and popped when the DUT transfers a word or pulses frame_done.
module tb_led_recv;
  localparam int LED_NUM    = 4;
  localparam int IDLE_CNT   = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int IW         = $clog2(LED_NUM);

  typedef struct packed {
    logic [23:0]   data;
    logic [IW-1:0] idx;
  } pix_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cko = 1'b0;
  logic sdi = 1'b0;
  logic frame_done, frame_err, ovf;

  led_recv_if #(.LED_NUM(LED_NUM)) pix ();

  led_recv #(.LED_NUM(LED_NUM), .IDLE_CNT(IDLE_CNT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cko_i      (cko),
    .sdi        (sdi),
    .pix        (pix),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  pix_t exp_pix[$];
  logic exp_frm[$];
  pix_t mon_e;
  logic mon_err;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_ready = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      if (pix.pix_valid && pix.pix_ready) begin
        if (exp_pix.size() == 0) check_val("pix_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_pix.pop_front();
          check_val("pix_data", pix.pix_data, mon_e.data);
          check_val("pix_idx", pix.pix_idx, mon_e.idx);
        end
      end
      if (frame_done) begin
        if (exp_frm.size() == 0) check_val("frame_unexpected", 32'd1, 32'd0);
        else begin
          mon_err = exp_frm.pop_front();
          check_val("frame_err", frame_err, mon_err);
        end
      end else if (frame_err) begin
        check_val("err_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tick();
    cko = 1'b0;
    sdi = b;
    if (rnd_ready) pix.pix_ready = 1'($urandom_range(0, 1));
    tick();
    cko = 1'b1;
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      tick();
      cko = 1'b0;
    end
  endtask

  // gap_at >= 0 inserts gap_len extra low cycles before bit (23 - gap_at)
  task automatic send_word(input logic [23:0] w, input bit exp_out, input int idx,
                           input int gap_at, input int gap_len);
    if (exp_out) exp_pix.push_back({w, IW'(idx)});
    for (int i = 23; i >= 0; i--) begin
      if (23 - i == gap_at) gap(gap_len);
      send_bit(w[i]);
    end
  endtask

  task automatic end_frame();
    tick();
    cko = 1'b0;
    repeat (IDLE_CNT + 10) tick();
  endtask

  task automatic check_drained(input string tag);
    repeat (10) tick();
    check_val({tag, "_pix_left"}, exp_pix.size(), 0);
    check_val({tag, "_frm_left"}, exp_frm.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [23:0] words [4];
    logic [23:0] w;
    words[0] = 24'h123456;
    words[1] = 24'h789ABC;
    words[2] = 24'hDEF012;
    words[3] = 24'h345678;
    pix.pix_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check_val("rst_valid", pix.pix_valid, 0);
    check_val("rst_data", pix.pix_data, 0);
    check_val("rst_idx", pix.pix_idx, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_ovf", ovf, 0);
    rstn = 1'b1;
    repeat (3) tick();

    // Four identical words, ready held high
    exp_frm.push_back(1'b0);
    for (int i = 0; i < 4; i++) send_word(24'h555555, 1'b1, i, -1, 0);
    end_frame();
    check_drained("t555");

    // Distinct words with random backpressure
    rnd_ready = 1'b1;
    exp_frm.push_back(1'b0);
    for (int i = 0; i < 4; i++) send_word(words[i], 1'b1, i, -1, 0);
    rnd_ready = 1'b0;
    pix.pix_ready = 1'b1;
    end_frame();
    check_drained("tord");

    // Short frame: 3 words plus 5 bits
    exp_frm.push_back(1'b1);
    for (int i = 0; i < 3; i++) send_word(words[3 - i], 1'b1, i, -1, 0);
    w = 24'hA5A5A5;
    for (int i = 23; i > 18; i--) send_bit(w[i]);
    end_frame();
    check_drained("tshort");

    // Overflow: full buffer from one frame, next frame's word dropped
    pix.pix_ready = 1'b0;
    exp_frm.push_back(1'b0);
    for (int i = 0; i < 4; i++) send_word(words[i] ^ 24'h0F0F0F, 1'b1, i, -1, 0);
    end_frame();
    check_val("ovf_pre", ovf, 0);
    check_val("full_valid", pix.pix_valid, 1);
    check_val("hold_data", pix.pix_data, words[0] ^ 24'h0F0F0F);
    exp_frm.push_back(1'b1);
    send_word(24'hFFFFFF, 1'b0, 0, -1, 0);
    end_frame();
    check_val("ovf_set", ovf, 1);
    check_val("hold_data2", pix.pix_data, words[0] ^ 24'h0F0F0F);
    check_val("hold_idx", pix.pix_idx, 0);
    pix.pix_ready = 1'b1;
    check_drained("tovf");

    // Reset in the middle of a frame
    w = 24'hC3C3C3;
    for (int i = 23; i > 13; i--) send_bit(w[i]);
    tick();
    rstn = 1'b0;
    cko  = 1'b0;
    #1;
    check_val("mrst_valid", pix.pix_valid, 0);
    check_val("mrst_data", pix.pix_data, 0);
    check_val("mrst_done", frame_done, 0);
    check_val("mrst_err", frame_err, 0);
    check_val("mrst_ovf", ovf, 0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (IDLE_CNT + 10) tick();
    check_val("mrst_quiet_frm", exp_frm.size(), 0);
    exp_frm.push_back(1'b0);
    for (int i = 0; i < 4; i++) send_word(words[i], 1'b1, i, -1, 0);
    end_frame();
    check_drained("tmrst");

    // Gap of IDLE_CNT-2 between bits does not end the frame
    exp_frm.push_back(1'b0);
    for (int i = 0; i < 4; i++) send_word(words[i] + 24'd1, 1'b1, i, (i == 1) ? 12 : -1, IDLE_CNT - 2);
    end_frame();
    check_drained("tgap_short");

    // Gap of IDLE_CNT between bits ends the frame early
    exp_frm.push_back(1'b1);
    exp_frm.push_back(1'b1);
    send_word(24'h0A0B0C, 1'b1, 0, -1, 0);
    w = 24'h13579B;
    for (int i = 23; i > 11; i--) send_bit(w[i]);
    gap(IDLE_CNT);
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
    end_frame();
    check_drained("tgap_long");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
